// File: rtl/md_unit_if.sv
// Operand/result bundle between the E-stage pipeline (master) and md_unit (slave).
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, md_op, rs_data, rt_data, pc,
        input  busy, hi_out, lo_out
    );

    modport slave (
        input  start, md_op, rs_data, rt_data, pc,
        output busy, hi_out, lo_out
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional trace of every HI/LO write is enabled by defining MD_TRACE_EN.
//
// state | meaning
// IDLE  | counter == 0, accepts mult/div/mthi/mtlo starts
// RUN   | counter != 0, operation in flight, all starts ignored
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic [2:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic [31:0]   hi_q, lo_q;

    logic          is_mul, is_div;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    assign is_mul = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign is_div = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV: begin
                // Divide by zero leaves HI/LO untouched; the overflow case is pinned explicitly.
                if (b_q != 32'd0) begin
                    res_wr = 1'b1;
                    if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = 32'd0;
                    end else begin
                        res_lo = $signed(a_q) / $signed(b_q);
                        res_hi = $signed(a_q) % $signed(b_q);
                    end
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_wr = 1'b1;
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mul || is_div) begin
                            op_q   <= bus.md_op;
                            a_q    <= bus.rs_data;
                            b_q    <= bus.rt_data;
                            cnt    <= is_mul ? CW'(MULT_LAT) : CW'(DIV_LAT);
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else if (bus.md_op == OP_MTHI) begin
                            hi_q <= bus.rs_data;
                        end else if (bus.md_op == OP_MTLO) begin
                            lo_q <= bus.rs_data;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MD_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (state == IDLE && bus.start && (is_mul || is_div)) begin
            pc_q <= bus.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == RUN && cnt == CW'(1) && res_wr) begin
                $display("%0t pc=%08h HI <= %08h", $time, pc_q, res_hi);
                $display("%0t pc=%08h LO <= %08h", $time, pc_q, res_lo);
            end else if (state == IDLE && bus.start && bus.md_op == OP_MTHI) begin
                $display("%0t pc=%08h HI <= %08h", $time, bus.pc, bus.rs_data);
            end else if (state == IDLE && bus.start && bus.md_op == OP_MTLO) begin
                $display("%0t pc=%08h LO <= %08h", $time, bus.pc, bus.rs_data);
            end
        end
    end
`endif

    assign bus.busy   = busy_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule
